stack_frame_ctrl: RTL

Sequencer that owns the EBP/ESP frame-pointer pair and executes ENTER-style frame setup and LEAVE-style frame teardown as multi-cycle operations against a shared data-memory port. Sits between the instruction decoder (op requests, direct MOV writes) and the data memory bus. Arbitrates register writes so that frame sequences and direct writes never collide. Single clock domain; replaces per-phase register write strobes.

---
 rtl/stack_frame_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/stack_frame_ctrl.sv
// stack_frame_ctrl: EBP/ESP owner running ENTER/LEAVE frame sequences.
// Optional ENTER stack-limit abort when STACK_FRAME_LIMIT_EN is defined.
module stack_frame_ctrl #(
  parameter logic [31:0] EBP_RESET = 32'h0000_0999,
  parameter logic [31:0] ESP_RESET = 32'h0000_1000
`ifdef STACK_FRAME_LIMIT_EN
  ,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_code,
  input  logic [15:0] op_alloc,
  output logic        op_ready,
  output logic        done,
  output logic        err,
  input  logic        wr_valid,
  input  logic        wr_sel,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ebp,
  output logic [31:0] esp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic        code_q;
  logic [15:0] alloc_q;
  logic [31:0] rdata_q;
  logic [31:0] ebp_q;
  logic [31:0] esp_q;
  logic [31:0] esp_m4;
  logic        idle;
  logic        in_mem;
  logic        abort;

  assign idle   = (state == S_IDLE);
  assign in_mem = (state == S_MEM);
  assign esp_m4 = esp_q - 32'd4;

`ifdef STACK_FRAME_LIMIT_EN
  logic [32:0] lim_calc;
  logic        err_q;

  assign lim_calc = {1'b0, esp_q} - 33'd4
                  - {17'd0, op_alloc};
  assign abort = ~op_code &
                 (lim_calc[32] |
                  (lim_calc[31:0] < STACK_LIMIT));

  // Remember whether the accepted op was aborted
  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (idle && op_valid)
      err_q <= abort;
  end

  assign err = (state == S_DONE) & err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  // Frame sequencer and register arbitration
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      code_q  <= 1'b0;
      alloc_q <= 16'd0;
      rdata_q <= 32'd0;
      ebp_q   <= EBP_RESET;
      esp_q   <= ESP_RESET;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (op_valid) begin
            code_q  <= op_code;
            alloc_q <= op_alloc;
            state   <= abort ? S_DONE : S_MEM;
          end else if (wr_valid) begin
            if (wr_sel)
              esp_q <= wr_data;
            else
              ebp_q <= wr_data;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state   <= S_UPD;
          end
        end
        S_UPD: begin
          if (!code_q) begin
            ebp_q <= esp_m4;
            esp_q <= esp_m4 - {16'd0, alloc_q};
          end else begin
            esp_q <= ebp_q + 32'd4;
            ebp_q <= rdata_q;
          end
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory port driven only while in MEM; regs frozen there
  always_comb begin
    mem_req   = in_mem;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    unique case (1'b1)
      in_mem && !code_q: begin
        mem_we    = 1'b1;
        mem_addr  = esp_m4;
        mem_wdata = ebp_q;
      end
      in_mem && code_q: begin
        mem_addr = ebp_q;
      end
      default: ;
    endcase
  end

  assign op_ready = idle;
  assign wr_ready = idle & ~op_valid;
  assign done     = (state == S_DONE);
  assign ebp      = ebp_q;
  assign esp      = esp_q;

endmodule
